// File: rtl/risc_v_dmem_responder.sv
// Multi-cycle data-memory responder for the M-stage load/store port: one access in flight,
// fixed latency. Optional misaligned-access check under `DMEM_MISALIGN_CHECK_EN`.
module risc_v_dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic        resp_err,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [31:0]         mem [DEPTH];
    logic                wr_q, err_q, err_r;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   req_idx, cur_idx;
    logic                accept, enter_resp, misalign, cur_wr, cur_err;

    assign req_idx    = req_addr[ADDR_W+1:2];
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
    assign resp_err = err_r;
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];
`else
    assign misalign = 1'b0;
    logic unused_sigs;
    assign unused_sigs = ^{req_addr[31:ADDR_W+2], req_addr[1:0], err_r};
`endif

    // With LATENCY==1 the response is captured on the accept edge itself,
    // so the access attributes come straight from the request port.
    assign cur_wr  = (state == IDLE) ? req_write : wr_q;
    assign cur_idx = (state == IDLE) ? req_idx   : idx_q;
    assign cur_err = (state == IDLE) ? misalign  : err_q;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            resp_rdata <= 32'd0;
            err_r      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                wr_q  <= req_write;
                idx_q <= req_idx;
                err_q <= misalign;
                if (req_write && !misalign) mem[req_idx] <= req_wdata;
            end
            if (enter_resp) begin
                resp_rdata <= (cur_wr || cur_err) ? 32'd0 : mem[cur_idx];
                err_r      <= cur_err;
            end
        end
    end

endmodule

// File: tb/tb_risc_v_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=1 sharing the request bus.
module tb_risc_v_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic        v0, v1, rr0, rr1;
    logic        rdy0, rdy1, rv0, rv1, busy0, busy1;
    logic [31:0] rd0, rd1;
    logic        err0, err1;
    bit          cur;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    risc_v_dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(rr0),
        .resp_rdata(rd0),
`ifdef DMEM_MISALIGN_CHECK_EN
        .resp_err(err0),
`endif
        .busy(busy0));

    risc_v_dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(rr1),
        .resp_rdata(rd1),
`ifdef DMEM_MISALIGN_CHECK_EN
        .resp_err(err1),
`endif
        .busy(busy1));

`ifndef DMEM_MISALIGN_CHECK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on the selected DUT, wait (bounded) for its response and hand it off.
    task automatic access(input bit which, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int lat);
        cur       = which;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        if (which) v1 = 1'b1; else v0 = 1'b1;
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
        lat = 1;
        while (!(which ? rv1 : rv0) && lat < 20) begin
            tick();
            lat++;
        end
        rd  = which ? rd1 : rd0;
        err = which ? err1 : err0;
        if (which) rr1 = 1'b1; else rr0 = 1'b1;
        tick();
        rr0 = 1'b0;
        rr1 = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;

    initial begin
        rst = 1'b1; v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        req_write = 0; req_addr = 0; req_wdata = 0; cur = 0;
        tick(); tick();
        rst = 1'b0;
        check("rst_req_ready", {31'd0, rdy0}, 32'd1);
        check("rst_resp_valid", {31'd0, rv0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_rdata", rd0, 32'd0);

        // 1: load 0x10 after reset, cycle-accurate handshake
        req_write = 0; req_addr = 32'h10; v0 = 1;
        tick();
        v0 = 0;
        check("t1_ready_after_accept", {31'd0, rdy0}, 32'd0);
        check("t1_valid_early", {31'd0, rv0}, 32'd0);
        check("t1_busy", {31'd0, busy0}, 32'd1);
        tick();
        check("t1_valid", {31'd0, rv0}, 32'd1);
        check("t1_rdata", rd0, 32'd0);
        check("t1_ready_in_resp", {31'd0, rdy0}, 32'd0);
        rr0 = 1;
        tick();
        rr0 = 0;
        check("t1_valid_after_handoff", {31'd0, rv0}, 32'd0);
        check("t1_ready_after_handoff", {31'd0, rdy0}, 32'd1);

        // 2: store then load same word
        access(0, 1, 32'h0C, 32'hDEAD_BEEF, rd, err, lat);
        check("t2_store_rdata", rd, 32'd0);
        check("t2_store_lat", lat, 32'd2);
        access(0, 0, 32'h0C, 32'd0, rd, err, lat);
        check("t2_load_rdata", rd, 32'hDEAD_BEEF);
        check("t2_load_lat", lat, 32'd2);

        // 3: stalled response; a request pulse in the window must be ignored
        req_write = 0; req_addr = 32'h0C; v0 = 1;
        tick();
        v0 = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_valid_held", {31'd0, rv0}, 32'd1);
            check("t3_rdata_held", rd0, 32'hDEAD_BEEF);
            check("t3_ready_low", {31'd0, rdy0}, 32'd0);
            check("t3_busy", {31'd0, busy0}, 32'd1);
            req_write = 1; req_addr = 32'h0C; req_wdata = 32'h1111_1111; v0 = (i == 1);
            tick();
        end
        v0 = 0;
        rr0 = 1;
        tick();
        rr0 = 0;
        tick();
        check("t3_no_extra_resp", {31'd0, rv0}, 32'd0);
        check("t3_idle", {31'd0, busy0}, 32'd0);
        access(0, 0, 32'h0C, 32'd0, rd, err, lat);
        check("t3_ignored_store", rd, 32'hDEAD_BEEF);

        // 4: index wrap, both latencies
        access(0, 1, 32'h80, 32'h0000_1234, rd, err, lat);
        access(0, 0, 32'h00, 32'd0, rd, err, lat);
        check("t4_wrap_l2", rd, 32'h0000_1234);
        access(1, 1, 32'h80, 32'h0000_1234, rd, err, lat);
        check("t4_store_lat1", lat, 32'd1);
        check("t4_store_rdata_l1", rd, 32'd0);
        access(1, 0, 32'h00, 32'd0, rd, err, lat);
        check("t4_wrap_l1", rd, 32'h0000_1234);
        check("t4_load_lat1", lat, 32'd1);
        access(1, 0, 32'h7C, 32'd0, rd, err, lat);
        check("t4_other_word_l1", rd, 32'd0);

        // 5: reset drops the pending load and clears memory
        access(0, 1, 32'h04, 32'h55, rd, err, lat);
        access(0, 0, 32'h04, 32'd0, rd, err, lat);
        check("t5_pre_rdata", rd, 32'h55);
        req_write = 0; req_addr = 32'h04; v0 = 1;
        tick();
        v0 = 0;
        rst = 1;
        tick();
        rst = 0;
        check("t5_ready_after_rst", {31'd0, rdy0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_resp", {31'd0, rv0}, 32'd0);
            tick();
        end
        access(0, 0, 32'h04, 32'd0, rd, err, lat);
        check("t5_mem_cleared", rd, 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
        // 6: misaligned store is suppressed and flagged
        access(0, 1, 32'h0E, 32'hFFFF_FFFF, rd, err, lat);
        check("t6_err", {31'd0, err}, 32'd1);
        check("t6_err_rdata", rd, 32'd0);
        check("t6_err_lat", lat, 32'd2);
        access(0, 0, 32'h0C, 32'd0, rd, err, lat);
        check("t6_mem_unchanged", rd, 32'd0);
        check("t6_aligned_no_err", {31'd0, err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
